// File: rtl/vector_alu_pipe.sv
// Handshaked execute-stage vector ALU: LANES signed lanes of DATAWIDTH bits.
// Single-cycle ops load the output register at the accept edge. DIV runs a
// per-lane restoring divider, one quotient bit per cycle. The output register
// and its ovf/dbz masks are held until the consumer takes them.
module vector_alu_pipe #(
  parameter int LANES     = 4,
  parameter int DATAWIDTH = 16,
  parameter int SATURATE  = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 op,
  input  logic [LANES*DATAWIDTH-1:0] ra1,
  input  logic [LANES*DATAWIDTH-1:0] ra2,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*DATAWIDTH-1:0] result,
  output logic [LANES-1:0]           ovf,
  output logic [LANES-1:0]           dbz,
  output logic                       busy
);

  localparam int W  = DATAWIDTH;
  localparam int VW = LANES * DATAWIDTH;
  localparam int CW = $clog2(DATAWIDTH);
  localparam bit SAT_EN = (SATURATE != 0);

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_MUL    = 4'b0010;
  localparam logic [3:0] OP_COPY   = 4'b0011;
  localparam logic [3:0] OP_DIV    = 4'b0100;
  localparam logic [3:0] OP_ABSDIR = 4'b0101;
  localparam logic [3:0] OP_ERR    = 4'b0110;
  localparam logic [3:0] OP_MIN    = 4'b0111;
  localparam logic [3:0] OP_MAX    = 4'b1000;

  localparam logic [W-1:0]  ONE_W    = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]  MONE_W   = {W{1'b1}};
  localparam logic [W-1:0]  MIN_W    = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]  MAX_W    = {1'b0, {(W-1){1'b1}}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_LAST = CW'(DATAWIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DIV  = 2'b01,
    ST_HOLD = 2'b10
  } state_t;

  state_t state_q, state_d;

  logic [VW-1:0]              result_q, result_d;
  logic [LANES-1:0]           ovf_q, ovf_d;
  logic [LANES-1:0]           dbz_q, dbz_d;
  // dq holds the dividend magnitude, shifted out MSB-first while quotient
  // bits shift in from the bottom; after W steps it is the quotient.
  logic [LANES-1:0][W-1:0]    dq_q, dq_d;
  logic [LANES-1:0][W-1:0]    rem_q, rem_d;
  logic [LANES-1:0][W-1:0]    dvs_q, dvs_d;
  logic [LANES-1:0]           neg_q, neg_d;
  logic [LANES-1:0]           dz_q, dz_d;
  logic [LANES-1:0]           dov_q, dov_d;
  logic [CW-1:0]              cnt_q, cnt_d;

  logic                       accept_s;
  logic                       last_s;
  logic [VW-1:0]              alu_res_s;
  logic [LANES-1:0]           alu_ovf_s;
  logic [LANES-1:0][W-1:0]    rem_n_s;
  logic [LANES-1:0][W-1:0]    dq_n_s;
  logic [LANES-1:0]           qb_s;
  logic [VW-1:0]              div_res_s;

  // One lane of the element-wise ops; returns {ovf, value}.
  function automatic logic [W:0] lane_op(input logic [3:0] opc,
                                         input logic signed [W-1:0] a,
                                         input logic signed [W-1:0] b);
    logic signed [W-1:0] sum, dif, lo, val;
    logic [2*W-1:0]      prod;
    logic                ov;
    sum  = a + b;
    dif  = a - b;
    prod = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};
    lo   = prod[W-1:0];
    ov   = 1'b0;
    val  = {W{1'b0}};
    case (opc)
      OP_ADD: begin
        ov  = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
        val = (ov && SAT_EN) ? (a[W-1] ? MIN_W : MAX_W) : sum;
      end
      OP_SUB: begin
        ov  = (a[W-1] != b[W-1]) && (dif[W-1] != a[W-1]);
        val = (ov && SAT_EN) ? (a[W-1] ? MIN_W : MAX_W) : dif;
      end
      OP_MUL: begin
        ov  = (prod != {{W{lo[W-1]}}, lo});
        val = (ov && SAT_EN) ? (prod[2*W-1] ? MIN_W : MAX_W) : lo;
      end
      OP_COPY: val = b;
      OP_MIN:  val = (a < b) ? a : b;
      OP_MAX:  val = (a < b) ? b : a;
      default: val = {W{1'b0}};
    endcase
    return {ov, val};
  endfunction

  // ABSDIR on one group of four lanes taken from ra1.
  function automatic logic [4*W-1:0] absdir_grp(input logic [4*W-1:0] g);
    logic signed [W-1:0] a0, a1, a2, a3;
    logic [W:0]          d31, d20;
    logic [W-1:0]        r3, r2, r1, r0;
    a0  = g[0 +: W];
    a1  = g[W +: W];
    a2  = g[2*W +: W];
    a3  = g[3*W +: W];
    d31 = {a1[W-1], a1} - {a3[W-1], a3};
    d20 = {a0[W-1], a0} - {a2[W-1], a2};
    // Low W bits of |d| at W+1 bits, i.e. the truncated magnitude.
    r3  = d31[W] ? (~d31[W-1:0] + ONE_W) : d31[W-1:0];
    r2  = d20[W] ? (~d20[W-1:0] + ONE_W) : d20[W-1:0];
    r1  = (a3 < a1) ? ONE_W : MONE_W;
    r0  = (a0 < a2) ? ONE_W : MONE_W;
    return {r3, r2, r1, r0};
  endfunction

  // Magnitude of a signed lane; MIN maps to 2^(W-1) as an unsigned value.
  function automatic logic [W-1:0] mag(input logic [W-1:0] v);
    return v[W-1] ? (~v + ONE_W) : v;
  endfunction

  // One restoring-divide step; returns {quotient bit, next remainder}.
  // The partial remainder stays below the divisor, so the shifted value
  // fits W bits whenever the subtraction is taken.
  function automatic logic [W:0] div_step(input logic [W-1:0] rem,
                                          input logic           msb,
                                          input logic [W-1:0] dvs);
    logic [W:0] sh;
    logic       geq;
    sh  = {rem, msb};
    geq = (sh >= {1'b0, dvs});
    return {geq, (geq ? (sh[W-1:0] - dvs) : sh[W-1:0])};
  endfunction

  assign accept_s = in_valid && in_ready;
  assign last_s   = (cnt_q == CNT_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE/HOLD accept, DIV iteration count, HOLD drain.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = (op == OP_DIV) ? ST_DIV : ST_HOLD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DIV: begin
        if (last_s) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_DIV;
        end
      end
      ST_HOLD: begin
        if (accept_s) begin
          state_d = (op == OP_DIV) ? ST_DIV : ST_HOLD;
        end else if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state register.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ST_IDLE: in_ready = 1'b1;
      ST_DIV:  busy     = 1'b1;
      ST_HOLD: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Single-cycle ALU: element-wise lanes, then group ops overwrite lanes.
  always_comb begin
    alu_res_s = {VW{1'b0}};
    alu_ovf_s = {LANES{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      {alu_ovf_s[i], alu_res_s[i*W +: W]} = lane_op(op, ra1[i*W +: W], ra2[i*W +: W]);
    end
    if (op == OP_ABSDIR) begin
      for (int g = 0; g < LANES / 4; g++) begin
        alu_res_s[g*4*W +: 4*W] = absdir_grp(ra1[g*4*W +: 4*W]);
      end
    end else if (op == OP_ERR) begin
      for (int g = 0; g < LANES / 4; g++) begin
        alu_res_s[g*4*W +: 4*W] = {ra1[(4*g+3)*W +: W] - ra1[(4*g+2)*W +: W],
                                   {(3*W){1'b0}}};
      end
    end else begin
      alu_ovf_s = alu_ovf_s;
    end
  end

  // Divider step for all lanes plus the sign/zero fix-up of the final quotient.
  always_comb begin
    rem_n_s   = rem_q;
    dq_n_s    = dq_q;
    qb_s      = {LANES{1'b0}};
    div_res_s = {VW{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      {qb_s[i], rem_n_s[i]} = div_step(rem_q[i], dq_q[i][W-1], dvs_q[i]);
      dq_n_s[i] = {dq_q[i][W-2:0], qb_s[i]};
      if (dz_q[i]) begin
        div_res_s[i*W +: W] = {W{1'b0}};
      end else begin
        div_res_s[i*W +: W] = neg_q[i] ? (~dq_n_s[i] + ONE_W) : dq_n_s[i];
      end
    end
  end

  // Datapath next state: capture on accept, iterate in DIV, load on last step.
  always_comb begin
    result_d = result_q;
    ovf_d    = ovf_q;
    dbz_d    = dbz_q;
    dq_d     = dq_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    neg_d    = neg_q;
    dz_d     = dz_q;
    dov_d    = dov_q;
    cnt_d    = cnt_q;
    if (accept_s && (op == OP_DIV)) begin
      for (int i = 0; i < LANES; i++) begin
        dq_d[i]  = mag(ra1[i*W +: W]);
        dvs_d[i] = mag(ra2[i*W +: W]);
        rem_d[i] = {W{1'b0}};
        neg_d[i] = ra1[i*W + W - 1] ^ ra2[i*W + W - 1];
        dz_d[i]  = (ra2[i*W +: W] == {W{1'b0}});
        dov_d[i] = (ra1[i*W +: W] == MIN_W) && (ra2[i*W +: W] == MONE_W);
      end
      cnt_d = {CW{1'b0}};
    end else if (accept_s) begin
      result_d = alu_res_s;
      ovf_d    = alu_ovf_s;
      dbz_d    = {LANES{1'b0}};
    end else if (state_q == ST_DIV) begin
      dq_d  = dq_n_s;
      rem_d = rem_n_s;
      cnt_d = cnt_q + CNT_ONE;
      if (last_s) begin
        result_d = div_res_s;
        ovf_d    = dov_q;
        dbz_d    = dz_q;
      end else begin
        result_d = result_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Datapath registers; reset discards any in-flight divide or held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= {VW{1'b0}};
      ovf_q    <= {LANES{1'b0}};
      dbz_q    <= {LANES{1'b0}};
      dq_q     <= {(LANES*W){1'b0}};
      rem_q    <= {(LANES*W){1'b0}};
      dvs_q    <= {(LANES*W){1'b0}};
      neg_q    <= {LANES{1'b0}};
      dz_q     <= {LANES{1'b0}};
      dov_q    <= {LANES{1'b0}};
      cnt_q    <= {CW{1'b0}};
    end else begin
      result_q <= result_d;
      ovf_q    <= ovf_d;
      dbz_q    <= dbz_d;
      dq_q     <= dq_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      neg_q    <= neg_d;
      dz_q     <= dz_d;
      dov_q    <= dov_d;
      cnt_q    <= cnt_d;
    end
  end

  assign result = result_q;
  assign ovf    = ovf_q;
  assign dbz    = dbz_q;

endmodule

// File: tb/tb_vector_alu_pipe.sv
// Self-checking bench for vector_alu_pipe: a wrapping instance and a
// saturating instance driven in parallel, checked against an integer model.
module tb_vector_alu_pipe;

  localparam int L  = 4;
  localparam int W  = 16;
  localparam int VW = L * W;
  localparam int RW = VW + 2 * L;
  localparam longint MAXV = (longint'(1) <<< (W - 1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (W - 1));

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          out_ready;
  logic [3:0]    op;
  logic [VW-1:0] ra1, ra2;

  logic          in_ready, out_valid, busy;
  logic [VW-1:0] result;
  logic [L-1:0]  ovf, dbz;
  logic          in_ready_s, out_valid_s, busy_s;
  logic [VW-1:0] result_s;
  logic [L-1:0]  ovf_s, dbz_s;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vector_alu_pipe #(.LANES(L), .DATAWIDTH(W), .SATURATE(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .ra1(ra1), .ra2(ra2), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .ovf(ovf), .dbz(dbz), .busy(busy));

  vector_alu_pipe #(.LANES(L), .DATAWIDTH(W), .SATURATE(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .op(op), .ra1(ra1), .ra2(ra2), .out_valid(out_valid_s), .out_ready(out_ready),
    .result(result_s), .ovf(ovf_s), .dbz(dbz_s), .busy(busy_s));

  function automatic longint lane(input logic [VW-1:0] v, input int i);
    logic signed [W-1:0] t;
    t = v[i*W +: W];
    return longint'(t);
  endfunction

  // Reference model from the arithmetic rules: returns {result, ovf, dbz}.
  function automatic logic [RW-1:0] model(input logic [3:0] opc, input logic [VW-1:0] a,
                                          input logic [VW-1:0] b, input bit sat);
    logic [VW-1:0] r;
    logic [L-1:0]  o, z;
    longint x, y, v, a0, a1, a2, a3, q0, q1, q2, q3;
    r = '0; o = '0; z = '0;
    for (int i = 0; i < L; i++) begin
      x = lane(a, i);
      y = lane(b, i);
      v = 0;
      case (opc)
        4'd0, 4'd1, 4'd2: begin
          v = (opc == 4'd0) ? x + y : (opc == 4'd1) ? x - y : x * y;
          if (v > MAXV || v < MINV) begin
            o[i] = 1'b1;
            if (sat) v = (v > MAXV) ? MAXV : MINV;
          end
        end
        4'd3: v = y;
        4'd4: begin
          if (y == 0) begin
            v = 0; z[i] = 1'b1;
          end else if (x == MINV && y == -1) begin
            v = MINV; o[i] = 1'b1;
          end else begin
            v = x / y;
          end
        end
        4'd7: v = (x < y) ? x : y;
        4'd8: v = (x > y) ? x : y;
        default: v = 0;
      endcase
      r[i*W +: W] = v[W-1:0];
    end
    if (opc == 4'd5 || opc == 4'd6) begin
      for (int g = 0; g < L / 4; g++) begin
        a0 = lane(a, 4*g); a1 = lane(a, 4*g+1); a2 = lane(a, 4*g+2); a3 = lane(a, 4*g+3);
        if (opc == 4'd5) begin
          q3 = (a1 - a3 < 0) ? a3 - a1 : a1 - a3;
          q2 = (a0 - a2 < 0) ? a2 - a0 : a0 - a2;
          q1 = (a3 < a1) ? 1 : -1;
          q0 = (a0 < a2) ? 1 : -1;
        end else begin
          q3 = a3 - a2; q2 = 0; q1 = 0; q0 = 0;
        end
        r[(4*g)*W +: W]   = q0[W-1:0];
        r[(4*g+1)*W +: W] = q1[W-1:0];
        r[(4*g+2)*W +: W] = q2[W-1:0];
        r[(4*g+3)*W +: W] = q3[W-1:0];
      end
    end
    return {r, o, z};
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'h0000;
      3: return 16'hFFFF;
      4: return 16'(signed'($urandom_range(0, 20)) - 10);
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < L; i++) v[i*W +: W] = pick();
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation for exactly one edge, then scramble the inputs.
  task automatic issue(input logic [3:0] o, input logic [VW-1:0] a, input logic [VW-1:0] b);
    op = o; ra1 = a; ra2 = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    op = 4'($urandom); ra1 = {$urandom, $urandom}; ra2 = {$urandom, $urandom};
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [VW-1:0] a, b;
    bit seen;
    tests++;
    if ({out_valid, busy, result, ovf, dbz, in_ready} !== {1'b0, 1'b0, {VW{1'b0}}, 4'b0, 4'b0, 1'b1}) begin
      $display("FAIL reset_state: got v=%b busy=%b res=%h ovf=%b dbz=%b rdy=%b want 0 0 0 0 0 1",
               out_valid, busy, result, ovf, dbz, in_ready);
      fails++;
    end
    rst_n = 1'b1;
    tick();
    issue(4'd0, {16'd1, 16'd2, 16'd3, 16'd4}, {16'd5, 16'd6, 16'd7, 16'd8});
    consume();
    a = {16'd9, 16'd9, 16'd9, 16'd9};
    b = {16'd2, 16'd2, 16'd2, 16'd2};
    issue(4'd4, a, b);
    repeat (5) tick();
    tests++;
    if (busy !== 1'b1) begin
      $display("FAIL reset_pre_busy: got %b want 1", busy);
      fails++;
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({out_valid, busy, result} !== {1'b0, 1'b0, {VW{1'b0}}}) begin
      $display("FAIL reset_mid_div: got v=%b busy=%b res=%h want 0 0 0", out_valid, busy, result);
      fails++;
    end
    tick();
    rst_n = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      $display("FAIL reset_release_ready: got %b want 1", in_ready);
      fails++;
    end
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    tests++;
    if (seen) begin
      $display("FAIL reset_discard: got stray out_valid/busy want none");
      fails++;
    end
  endtask

  task automatic test_add();
    logic [VW-1:0] a, b;
    logic [RW-1:0] e0, e1;
    a = {pick(), pick(), 16'd5, 16'h7FFF};
    b = {pick(), pick(), 16'hFFFD, 16'h0001};
    e0 = model(4'd0, a, b, 1'b0);
    e1 = model(4'd0, a, b, 1'b1);
    issue(4'd0, a, b);
    tests++;
    if (out_valid !== 1'b1) begin
      $display("FAIL add_latency: got out_valid=%b want 1", out_valid);
      fails++;
    end
    tests++;
    if ({result[31:0], ovf[1:0]} !== {16'd2, 16'h8000, 2'b01}) begin
      $display("FAIL add_wrap: got %h ovf=%b want 00028000 ovf=01", result[31:0], ovf[1:0]);
      fails++;
    end
    tests++;
    if (result_s[15:0] !== 16'h7FFF || ovf_s[0] !== 1'b1) begin
      $display("FAIL add_sat: got %h ovf=%b want 7fff ovf=1", result_s[15:0], ovf_s[0]);
      fails++;
    end
    tests++;
    if ({result, ovf, dbz} !== e0 || {result_s, ovf_s, dbz_s} !== e1) begin
      $display("FAIL add_model: got %h/%h want %h/%h", {result, ovf, dbz}, {result_s, ovf_s, dbz_s}, e0, e1);
      fails++;
    end
    consume();
  endtask

  task automatic test_div();
    logic [VW-1:0] a, b;
    int n, busy_n;
    bit bad;
    a = {16'h8000, 16'd100, 16'd7, 16'hFFF9};
    b = {16'hFFFF, 16'd0, 16'hFFFE, 16'd2};
    out_ready = 1'b0;
    issue(4'd4, a, b);
    n = 0; busy_n = 0; bad = 1'b0;
    while (!out_valid && n < 40) begin
      if (busy === 1'b1) busy_n++;
      if (in_ready !== 1'b0) bad = 1'b1;
      tick();
      n++;
    end
    tests++;
    if (n != W || busy_n != W || busy !== 1'b0) begin
      $display("FAIL div_latency: got valid_after=%0d busy_cycles=%0d busy=%b want %0d %0d 0", n, busy_n, busy, W, W);
      fails++;
    end
    tests++;
    if (bad) begin
      $display("FAIL div_ready: got in_ready=1 during divide want 0");
      fails++;
    end
    tests++;
    if ({result, ovf, dbz} !== {16'h8000, 16'h0000, 16'hFFFD, 16'hFFFD, 4'b1000, 4'b0100}) begin
      $display("FAIL div_result: got %h ovf=%b dbz=%b want 80000000fffdfffd ovf=1000 dbz=0100", result, ovf, dbz);
      fails++;
    end
    tests++;
    if ({result, ovf, dbz} !== model(4'd4, a, b, 1'b0)) begin
      $display("FAIL div_model: got %h want %h", {result, ovf, dbz}, model(4'd4, a, b, 1'b0));
      fails++;
    end
    consume();
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] a, b;
    logic [RW-1:0] e;
    bit bad;
    a = rand_vec(); b = rand_vec();
    e = model(4'd2, a, b, 1'b0);
    out_ready = 1'b0;
    issue(4'd2, a, b);
    bad = 1'b0;
    repeat (5) begin
      if ({out_valid, in_ready, result, ovf, dbz} !== {1'b1, 1'b0, e}) bad = 1'b1;
      tick();
    end
    tests++;
    if (bad || {result, ovf, dbz} !== e) begin
      $display("FAIL hold_stable: got v=%b rdy=%b %h want 1 0 %h", out_valid, in_ready, {result, ovf, dbz}, e);
      fails++;
    end
    a = rand_vec(); b = rand_vec();
    e = model(4'd1, a, b, 1'b0);
    out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      $display("FAIL b2b_ready: got %b want 1", in_ready);
      fails++;
    end
    issue(4'd1, a, b);
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || {result, ovf, dbz} !== e) begin
      $display("FAIL b2b_sub: got v=%b %h want 1 %h", out_valid, {result, ovf, dbz}, e);
      fails++;
    end
    consume();
    tests++;
    if (out_valid !== 1'b0) begin
      $display("FAIL drain_idle: got out_valid=%b want 0", out_valid);
      fails++;
    end
  endtask

  task automatic test_absdir();
    issue(4'd5, {16'd3, 16'd7, 16'd10, 16'd2}, {$urandom, $urandom});
    tests++;
    if ({result, ovf, dbz} !== {16'd7, 16'd5, 16'd1, 16'd1, 8'h00}) begin
      $display("FAIL absdir_pos: got %h %b %b want 0007000500010001 0000 0000", result, ovf, dbz);
      fails++;
    end
    consume();
    issue(4'd5, {16'd10, 16'd2, 16'd3, 16'd7}, {$urandom, $urandom});
    tests++;
    if ({result, ovf, dbz} !== {16'd7, 16'd5, 16'hFFFF, 16'hFFFF, 8'h00}) begin
      $display("FAIL absdir_neg: got %h %b %b want 00070005ffffffff 0000 0000", result, ovf, dbz);
      fails++;
    end
    consume();
  endtask

  task automatic test_zero_minmax();
    logic [VW-1:0] a, b;
    a = {4{16'hFFFB}};
    b = {4{16'd4}};
    issue(4'b1111, a, b);
    tests++;
    if ({result, ovf, dbz} !== {{VW{1'b0}}, 8'h00}) begin
      $display("FAIL zero_op: got %h %b %b want all 0", result, ovf, dbz);
      fails++;
    end
    consume();
    issue(4'd7, a, b);
    tests++;
    if ({result, ovf, dbz} !== {{4{16'hFFFB}}, 8'h00}) begin
      $display("FAIL min_op: got %h %b %b want fffb x4 flags 0", result, ovf, dbz);
      fails++;
    end
    consume();
    issue(4'd8, a, b);
    tests++;
    if ({result, ovf, dbz} !== {{4{16'd4}}, 8'h00}) begin
      $display("FAIL max_op: got %h %b %b want 0004 x4 flags 0", result, ovf, dbz);
      fails++;
    end
    consume();
  endtask

  task automatic test_random();
    logic [VW-1:0] a, b;
    logic [3:0]    o;
    logic [RW-1:0] e0, e1;
    int n;
    for (int k = 0; k < 80; k++) begin
      o = 4'($urandom_range(0, 15));
      a = rand_vec(); b = rand_vec();
      e0 = model(o, a, b, 1'b0);
      e1 = model(o, a, b, 1'b1);
      tests++;
      if (in_ready !== 1'b1) begin
        $display("FAIL rand_ready[%0d]: got %b want 1", k, in_ready);
        fails++;
      end
      issue(o, a, b);
      wait_valid(n);
      tests++;
      if (n != ((o == 4'd4) ? W : 0)) begin
        $display("FAIL rand_latency[%0d] op=%0d: got %0d want %0d", k, o, n, (o == 4'd4) ? W : 0);
        fails++;
      end
      repeat ($urandom_range(0, 2)) tick();
      tests++;
      if ({result, ovf, dbz} !== e0) begin
        $display("FAIL rand_wrap[%0d] op=%0d a=%h b=%h: got %h want %h", k, o, a, b, {result, ovf, dbz}, e0);
        fails++;
      end
      tests++;
      if ({result_s, ovf_s, dbz_s} !== e1) begin
        $display("FAIL rand_sat[%0d] op=%0d a=%h b=%h: got %h want %h", k, o, a, b, {result_s, ovf_s, dbz_s}, e1);
        fails++;
      end
      consume();
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 4'd0; ra1 = '0; ra2 = '0;
    repeat (3) tick();
    test_reset();
    test_add();
    test_div();
    test_back_to_back();
    test_absdir();
    test_zero_minmax();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
